// File: rtl/sa_job_sequencer.sv
`default_nettype none
// ============================================================================
// sa_job_sequencer : runs one systolic-array job (write, load, matmul, read)
// Revision: 1.0
// ============================================================================
module sa_job_sequencer #(
   parameter int ROWS        = 16,
   parameter int COLS        = 8,
   parameter int RD_ROWS     = 8,
   parameter int LOAD_CYCLES = 10,
   parameter int MM_CYCLES   = 25,
   parameter int RD_TIMEOUT  = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        err,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [18:0] res_data,
   output logic        res_valid,
   input  logic        res_ready,
   output logic        sa_write,
   output logic        sa_load,
   output logic [2:0]  sa_idx,
   output logic [3:0]  sa_reg_select,
   output logic [7:0]  sa_data_in,
   input  logic        sa_output_en,
   input  logic [18:0] sa_data_out
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_WRITE  = 3'd1;
   localparam logic [2:0] S_LOAD   = 3'd2;
   localparam logic [2:0] S_MATMUL = 3'd3;
   localparam logic [2:0] S_READ   = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   localparam int WCW = $clog2(ROWS*COLS + 1);
   localparam int LCW = $clog2(LOAD_CYCLES + 1);
   localparam int MCW = $clog2(MM_CYCLES + 1);
   localparam int TCW = $clog2(RD_TIMEOUT + 1);
   localparam logic [WCW-1:0] C_WR_TOTAL    = WCW'(ROWS*COLS);
   localparam logic [LCW-1:0] C_LOAD_LAST   = LCW'(LOAD_CYCLES - 1);
   localparam logic [MCW-1:0] C_MM_LAST     = MCW'(MM_CYCLES - 1);
   localparam logic [TCW-1:0] C_TO_LAST     = TCW'(RD_TIMEOUT - 1);
   localparam logic [2:0]     C_COL_LAST    = 3'(COLS - 1);
   localparam logic [3:0]     C_RD_ROW_LAST = 4'(RD_ROWS - 1);

   logic [2:0]     state_q, state_d;
   logic [WCW-1:0] wcnt_q, wcnt_d;
   logic [LCW-1:0] lcnt_q, lcnt_d;
   logic [MCW-1:0] mcnt_q, mcnt_d;
   logic [TCW-1:0] tmo_q, tmo_d;
   logic           wr_q, wr_d, ld_q, ld_d;
   logic [2:0]     idx_q, idx_d;
   logic [3:0]     row_q, row_d;
   logic [7:0]     din_q, din_d;
   logic [18:0]    rdat_q, rdat_d;
   logic           rv_q, rv_d, ir_q, ir_d;
   logic           busy_q, busy_d, done_q, done_d, err_q, err_d;

   logic       w_accept, w_hs, w_capture, w_timeout, w_rd_last;
   logic [2:0] w_idx_nxt;
   logic [3:0] w_row_nxt;

   assign w_accept  = in_valid && ir_q;
   assign w_hs      = rv_q && res_ready;
   // tmo_q == 0 marks the first cycle on a new address, which is never captured
   assign w_capture = (state_q == S_READ) && !rv_q && (tmo_q != '0) && sa_output_en;
   assign w_timeout = (state_q == S_READ) && !rv_q && !w_capture && (tmo_q == C_TO_LAST);
   assign w_rd_last = (row_q == C_RD_ROW_LAST) && (idx_q == C_COL_LAST);
   assign w_idx_nxt = (idx_q == C_COL_LAST) ? 3'd0 : idx_q + 3'd1;
   assign w_row_nxt = (idx_q == C_COL_LAST) ? row_q + 4'd1 : row_q;

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start)                       state_d = S_WRITE;
         S_WRITE:  if (wcnt_q == C_WR_TOTAL)        state_d = S_LOAD;
         S_LOAD:   if (lcnt_q == C_LOAD_LAST)       state_d = S_MATMUL;
         S_MATMUL: if (mcnt_q == C_MM_LAST)         state_d = S_READ;
         S_READ:   if ((w_hs && w_rd_last) || w_timeout) state_d = S_DONE;
         S_DONE:                                    state_d = S_IDLE;
         default:                                   state_d = S_IDLE;
      endcase
   end

   // Registered outputs are computed from the next state so they line up with it
   always_comb begin
      wcnt_d = wcnt_q;
      lcnt_d = lcnt_q;
      mcnt_d = mcnt_q;
      tmo_d  = tmo_q;
      wr_d   = 1'b1;
      ld_d   = 1'b1;
      idx_d  = idx_q;
      row_d  = row_q;
      din_d  = din_q;
      rdat_d = rdat_q;
      rv_d   = rv_q;
      err_d  = err_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               err_d  = 1'b0;
               wcnt_d = '0;
               lcnt_d = '0;
               mcnt_d = '0;
               tmo_d  = '0;
            end
         end
         S_WRITE: begin
            if (wcnt_q == C_WR_TOTAL) begin
               wr_d  = 1'b0;
               idx_d = '0;
               row_d = '0;
            end else if (w_accept) begin
               ld_d   = 1'b0;
               din_d  = in_data;
               wcnt_d = wcnt_q + WCW'(1);
               if (wcnt_q != '0) begin
                  idx_d = w_idx_nxt;
                  row_d = w_row_nxt;
               end
            end
         end
         S_LOAD: begin
            wr_d = 1'b0;
            ld_d = (lcnt_q != C_LOAD_LAST);
            if (lcnt_q != C_LOAD_LAST) lcnt_d = lcnt_q + LCW'(1);
         end
         S_MATMUL: begin
            if (mcnt_q != C_MM_LAST) begin
               wr_d   = 1'b0;
               ld_d   = 1'b0;
               mcnt_d = mcnt_q + MCW'(1);
            end
         end
         S_READ: begin
            if (w_capture) begin
               rdat_d = sa_data_out;
               rv_d   = 1'b1;
            end else if (w_timeout) begin
               err_d = 1'b1;
               rv_d  = 1'b0;
            end else if (!rv_q) begin
               tmo_d = tmo_q + TCW'(1);
            end
            if (w_hs) begin
               rv_d  = 1'b0;
               tmo_d = '0;
               idx_d = w_idx_nxt;
               row_d = w_row_nxt;
            end
         end
         default: ;
      endcase
      if (state_d == S_DONE) begin
         idx_d = '0;
         row_d = '0;
      end
      ir_d   = (state_d == S_WRITE) && (wcnt_d != C_WR_TOTAL);
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wcnt_q <= '0;
         lcnt_q <= '0;
         mcnt_q <= '0;
         tmo_q  <= '0;
         wr_q   <= 1'b1;
         ld_q   <= 1'b1;
         idx_q  <= '0;
         row_q  <= '0;
         din_q  <= '0;
         rdat_q <= '0;
         rv_q   <= 1'b0;
         ir_q   <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         wcnt_q <= wcnt_d;
         lcnt_q <= lcnt_d;
         mcnt_q <= mcnt_d;
         tmo_q  <= tmo_d;
         wr_q   <= wr_d;
         ld_q   <= ld_d;
         idx_q  <= idx_d;
         row_q  <= row_d;
         din_q  <= din_d;
         rdat_q <= rdat_d;
         rv_q   <= rv_d;
         ir_q   <= ir_d;
         busy_q <= busy_d;
         done_q <= done_d;
         err_q  <= err_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign err           = err_q;
   assign in_ready      = ir_q;
   assign res_data      = rdat_q;
   assign res_valid     = rv_q;
   assign sa_write      = wr_q;
   assign sa_load       = ld_q;
   assign sa_idx        = idx_q;
   assign sa_reg_select = row_q;
   assign sa_data_in    = din_q;
endmodule
`default_nettype wire

// File: tb/tb_sa_job_sequencer.sv
`default_nettype none
// ============================================================================
// tb_sa_job_sequencer : directed vector bench for sa_job_sequencer
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_sa_job_sequencer;
   localparam bit H = 1'b1;
   localparam bit L = 1'b0;

   logic        clk = 1'b0;
   logic        rst, start, busy, done, err;
   logic [7:0]  in_data, sa_data_in;
   logic        in_valid, in_ready, res_valid, res_ready;
   logic [18:0] res_data, sa_data_out;
   logic        sa_write, sa_load, sa_output_en, model_en;
   logic [2:0]  sa_idx;
   logic [3:0]  sa_reg_select;

   int checks = 0;
   int failures = 0;
   int wr_cycles = 0;
   logic [7:0] gb [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};

   always #5 clk = ~clk;

   // Engine model: result depends only on the column being read
   assign sa_output_en = model_en;
   assign sa_data_out  = (sa_idx == 3'd0) ? 19'h12345 : 19'h00001;

   always @(negedge clk) if (sa_write === 1'b1 && sa_load === 1'b0) wr_cycles <= wr_cycles + 1;

   sa_job_sequencer #(
      .ROWS(2), .COLS(2), .RD_ROWS(1), .LOAD_CYCLES(3), .MM_CYCLES(4), .RD_TIMEOUT(8)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
      .sa_write(sa_write), .sa_load(sa_load), .sa_idx(sa_idx),
      .sa_reg_select(sa_reg_select), .sa_data_in(sa_data_in),
      .sa_output_en(sa_output_en), .sa_data_out(sa_data_out)
   );

   typedef struct {
      bit         st;
      bit         iv;
      bit [7:0]   ind;
      bit         rr;
      logic [40:0] exp;
   } vec_t;
   vec_t tbl [21];

   function automatic logic [40:0] ov(bit b, bit ir, bit wr, bit ld, bit [2:0] idx, bit [3:0] row,
                                      bit [7:0] din, bit rv, bit [18:0] rd, bit dn, bit er);
      return {b, ir, wr, ld, idx, row, din, rv, rd, dn, er};
   endfunction

   function automatic vec_t mkv(bit st, bit iv, bit [7:0] ind, bit rr, logic [40:0] e);
      vec_t v;
      v.st = st; v.iv = iv; v.ind = ind; v.rr = rr; v.exp = e;
      return v;
   endfunction

   function automatic logic [40:0] obs();
      return {busy, in_ready, sa_write, sa_load, sa_idx, sa_reg_select, sa_data_in,
              res_valid, res_data, done, err};
   endfunction

   localparam logic [40:0] RST_V = {1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 4'd0, 8'd0, 1'b0, 19'd0, 1'b0, 1'b0};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic feed4(input bit [7:0] b0);
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = b0 + 8'(i);
         step();
      end
      in_valid = 1'b0;
   endtask

   task automatic init_table();
      tbl[0]  = mkv(H, H, 8'hEE, H, ov(H, H, H, H, 3'd0, 4'd0, 8'h00, L, 19'h0, L, L));
      tbl[1]  = mkv(L, H, 8'h11, H, ov(H, H, H, L, 3'd0, 4'd0, 8'h11, L, 19'h0, L, L));
      tbl[2]  = mkv(L, H, 8'h22, H, ov(H, H, H, L, 3'd1, 4'd0, 8'h22, L, 19'h0, L, L));
      tbl[3]  = mkv(L, H, 8'h33, H, ov(H, H, H, L, 3'd0, 4'd1, 8'h33, L, 19'h0, L, L));
      tbl[4]  = mkv(L, H, 8'h44, H, ov(H, L, H, L, 3'd1, 4'd1, 8'h44, L, 19'h0, L, L));
      for (int i = 5; i < 8; i++)
         tbl[i] = mkv(L, (i == 6), 8'hEE, H, ov(H, L, L, H, 3'd0, 4'd0, 8'h44, L, 19'h0, L, L));
      for (int i = 8; i < 12; i++)
         tbl[i] = mkv(L, L, 8'h00, H, ov(H, L, L, L, 3'd0, 4'd0, 8'h44, L, 19'h0, L, L));
      tbl[12] = mkv(L, L, 8'h00, H, ov(H, L, H, H, 3'd0, 4'd0, 8'h44, L, 19'h0, L, L));
      tbl[13] = mkv(L, L, 8'h00, H, ov(H, L, H, H, 3'd0, 4'd0, 8'h44, L, 19'h0, L, L));
      tbl[14] = mkv(L, L, 8'h00, H, ov(H, L, H, H, 3'd0, 4'd0, 8'h44, H, 19'h12345, L, L));
      tbl[15] = mkv(L, L, 8'h00, H, ov(H, L, H, H, 3'd1, 4'd0, 8'h44, L, 19'h12345, L, L));
      tbl[16] = mkv(L, L, 8'h00, H, ov(H, L, H, H, 3'd1, 4'd0, 8'h44, L, 19'h12345, L, L));
      tbl[17] = mkv(L, L, 8'h00, H, ov(H, L, H, H, 3'd1, 4'd0, 8'h44, H, 19'h00001, L, L));
      tbl[18] = mkv(L, L, 8'h00, H, ov(H, L, H, H, 3'd0, 4'd0, 8'h44, L, 19'h00001, H, L));
      tbl[19] = mkv(H, L, 8'h00, H, ov(L, L, H, H, 3'd0, 4'd0, 8'h44, L, 19'h00001, L, L));
      tbl[20] = mkv(L, L, 8'h00, H, ov(L, L, H, H, 3'd0, 4'd0, 8'h44, L, 19'h00001, L, L));
   endtask

   task automatic run_table(input string tag);
      for (int i = 0; i < 21; i++) begin
         start     = tbl[i].st;
         in_valid  = tbl[i].iv;
         in_data   = tbl[i].ind;
         res_ready = tbl[i].rr;
         step();
         chk($sformatf("%s_vec%0d", tag, i), 64'(obs()), 64'(tbl[i].exp));
      end
      start    = 1'b0;
      in_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      int  k, base, n;
      bit  seen, ivb;
      init_table();
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      res_ready = 1'b1; model_en = 1'b1;
      step(); step();
      chk("reset", 64'(obs()), 64'(RST_V));
      rst = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step();
         chk("idle_hold", 64'({sa_write, sa_load, busy}), 64'(3'b110));
      end

      run_table("job1");

      // Operand gaps followed by result backpressure in the same job
      start = 1'b1; step(); start = 1'b0;
      chk("gap_start", 64'({busy, in_ready}), 64'(2'b11));
      base = wr_cycles;
      k = 0;
      for (int j = 0; j < 10; j++) begin
         ivb      = (j % 3 == 0);
         in_valid = ivb;
         in_data  = ivb ? gb[k] : 8'hFF;
         step();
         if (ivb) k++;
         chk($sformatf("gap_c%0d", j),
             64'({sa_write, sa_load, in_ready, sa_idx, sa_reg_select, sa_data_in}),
             64'({1'b1, !ivb, (k < 4), 3'((k - 1) % 2), 4'((k - 1) / 2), gb[k - 1]}));
      end
      in_valid  = 1'b0;
      res_ready = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         step();
         seen = res_valid;
      end
      chk("bp_rv_wait", 64'(seen), 64'(1));
      for (int i = 0; i < 5; i++) begin
         start = (i == 2);
         step();
         chk($sformatf("bp_hold%0d", i),
             64'({res_valid, res_data, sa_idx, sa_reg_select, sa_write, sa_load}),
             64'({1'b1, 19'h12345, 3'd0, 4'd0, 1'b1, 1'b1}));
      end
      start = 1'b0;
      res_ready = 1'b1;
      step();
      chk("bp_adv", 64'({res_valid, sa_idx}), 64'({1'b0, 3'd1}));
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         step();
         seen = res_valid;
      end
      chk("r1_wait", 64'(seen), 64'(1));
      chk("r1_data", 64'(res_data), 64'(19'h00001));
      step();
      chk("bp_done", 64'({done, busy}), 64'(2'b11));
      step();
      chk("bp_idle", 64'({done, busy}), 64'(2'b00));
      chk("gap_wr_count", 64'(wr_cycles - base), 64'(4));

      // Timeout job, started in the first IDLE cycle after done
      model_en = 1'b0;
      start = 1'b1; step(); start = 1'b0;
      n = 1;
      feed4(8'h50);
      n += 4;
      seen = 1'b0;
      while (!seen && n < 60) begin
         step();
         n++;
         seen = done;
      end
      chk("to_cycle", 64'(n), 64'(21));
      chk("to_err", 64'({err, res_valid, done}), 64'(3'b101));
      step();
      chk("to_sticky", 64'({busy, err}), 64'(2'b01));
      start = 1'b1; step(); start = 1'b0;
      chk("err_clear", 64'({busy, err}), 64'(2'b10));

      // Same job is aborted by reset on its second matmul cycle
      feed4(8'h60);
      for (int i = 0; i < 5; i++) step();
      chk("mm2_mode", 64'({busy, sa_write, sa_load}), 64'(3'b100));
      rst = 1'b1; step(); rst = 1'b0;
      chk("rst_mid", 64'(obs()), 64'(RST_V));
      for (int i = 0; i < 5; i++) begin
         step();
         chk("rst_no_done", 64'({done, busy}), 64'(2'b00));
      end

      model_en = 1'b1;
      run_table("job2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
